ex_result_stage: RTL and testbench
==================================

Name: ex_result_stage

Overview:
- Execute-stage output register directly downstream of the ALU.
- Captures ALU result, destination and flags on a valid/ready handshake.
- Holds the architectural flag register and resolves conditional branches against it.
- Presents a one-entry registered result to the memory/writeback stage.

Parameters:
- DATA_W, 16, ALU result width.
- REG_IDX_W, 4, destination register index width.
- OPCODE_W, 5, opcode width.
- STAT_W, 32, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- alu_out  in  DATA_W  ALU result.
- alu_flags  in  3  ALU flags: [2] in1<in2, [1] in1==in2, [0] in1>in2 (signed).
- alu_set_flags  in  1  instruction writes the flag register (CMP/CMPR).
- in_opcode  in  OPCODE_W  opcode, passed through.
- in_dst  in  REG_IDX_W  destination register index.
- in_wb_en  in  1  instruction writes the register file.
- in_is_branch  in  1  instruction is a branch.
- in_br_cond  in  3  branch condition mask, same bit order as the flags.
- flush  in  1  kill the held entry and the incoming instruction.
- out_valid  out  1  held entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered result.
- out_opcode  out  OPCODE_W  registered opcode.
- out_dst  out  REG_IDX_W  registered destination.
- out_wb_en  out  1  registered write enable, forced 0 for branches.
- flags_q  out  3  architectural flag register.
- br_taken  out  1  one-cycle pulse: branch resolved taken.

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- On reset all outputs return to 0: out_valid=0, flags_q=3'b000, br_taken=0, all data fields 0. in_ready is combinational and goes to 1.
- in_ready = !out_valid | out_ready.
- accept = in_valid & in_ready & !flush.
- On accept, the entry loads at the next edge: out_valid=1, plus data, opcode, dst, and wb_en & !is_branch. Latency is 1 cycle.
- If out_valid & out_ready and there is no accept, out_valid clears at the next edge. Simultaneous drain and accept replaces the entry, giving back-to-back throughput.
- If out_valid & !out_ready, all out_* hold stable and in_ready=0.
- Flags: on accept & alu_set_flags, flags_q <= alu_flags at the edge. Otherwise flags_q holds. Flush and stall never modify flags_q.
- Branch: on accept & in_is_branch, br_taken <= (in_br_cond==3'b111) | |(in_br_cond & flags_q). Otherwise br_taken <= 0.
  - Evaluation uses flags_q as it stands before the edge, so CMP followed by a branch in the next accepted beat sees the CMP flags.
  - in_br_cond=3'b000 is never taken.
- An instruction with both set_flags and is_branch is legal. Its branch uses the old flags_q, and flags_q then updates.
- Flush: out_valid <= 0 at the next edge, no accept that cycle, br_taken <= 0. Flush has priority over out_ready and in_valid.
- Reset asserted mid-transfer discards the entry immediately (asynchronous clear).

Optional Feature:
- Macro: EX_RESULT_STATS_EN.
- When defined, adds three outputs:
  - stat_retired: counts cycles where out_valid & out_ready.
  - stat_br_taken: counts br_taken pulses.
  - stat_stall: counts cycles where out_valid & !out_ready.
- Each output is STAT_W wide, resets to 0, and wraps modulo 2^STAT_W with no saturation.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (CMP=5'b00110, CMPR=5'b00111, ADD=5'b10000, SUB=5'b10010, ...).
  - flag bit index constants FLAG_LT=2, FLAG_EQ=1, FLAG_GT=0.
  - BR_ALWAYS=3'b111.
  - packed struct ex_entry_t {data, opcode, dst, wb_en}.
- One sub-module, br_resolve: combinational taken = f(br_cond, flags_q), instantiated once.
- The stats counters are inline under the macro.

Test Plan:
- ADD: alu_out=16'hFFFF, in_dst=3, in_wb_en=1, out_ready=1 -> next cycle out_valid=1, out_data=FFFF, out_dst=3, out_wb_en=1; flags_q unchanged at 000.
- CMP then branch: beat 1 alu_flags=001, set_flags=1; beat 2 is_branch=1, br_cond=001 -> flags_q=001 after beat 1, br_taken=1 one cycle after beat 2, out_wb_en=0. Repeat with br_cond=100 -> br_taken=0.
- Backpressure: out_ready=0 for 3 cycles with entry data 1234 and a new in_valid -> in_ready=0, out_data stays 1234. Release -> 1234 retires, next entry appears the following cycle, nothing dropped or duplicated.
- Flush: entry valid and in_valid=1 with set_flags=1, alu_flags=100, flush=1 -> out_valid=0 next cycle, flags_q unchanged, br_taken=0.
- Async reset: assert rst mid-cycle with out_valid=1, flags_q=010 -> outputs clear before the next edge; after release in_ready=1.
- With EX_RESULT_STATS_EN and STAT_W=2: 5 retirements -> stat_retired=1 (wrap); 2 stall cycles -> stat_stall=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/execute definitions: opcode encodings, flag bit positions,
// branch-condition constants and the execute result entry layout.
// Used by ex_result_stage and br_resolve.
package alu_pkg;

   // Default datapath widths; ex_result_stage parameters must match these
   // because ex_entry_t is laid out with them.
   localparam int ALU_DATA_W    = 16;
   localparam int ALU_REG_IDX_W = 4;
   localparam int ALU_OPCODE_W  = 5;

   // Opcode encodings relevant to the execute stage.
   localparam logic [ALU_OPCODE_W-1:0] OP_CMP  = 5'b00110;
   localparam logic [ALU_OPCODE_W-1:0] OP_CMPR = 5'b00111;
   localparam logic [ALU_OPCODE_W-1:0] OP_ADD  = 5'b10000;
   localparam logic [ALU_OPCODE_W-1:0] OP_SUB  = 5'b10010;

   // Bit positions inside the 3-bit flag vector and the branch mask.
   localparam int FLAG_LT = 2;
   localparam int FLAG_EQ = 1;
   localparam int FLAG_GT = 0;

   // Branch-condition masks with special meaning.
   localparam logic [2:0] BR_ALWAYS = 3'b111;
   localparam logic [2:0] BR_NEVER  = 3'b000;

   // One registered execute result as handed to memory/writeback.
   typedef struct packed {
      logic [ALU_DATA_W-1:0]    data;
      logic [ALU_OPCODE_W-1:0]  opcode;
      logic [ALU_REG_IDX_W-1:0] dst;
      logic                     wb_en;
   } ex_entry_t;

endpackage

// File: rtl/br_resolve.sv
// Conditional branch resolver. Purely combinational: a branch is taken when
// its mask is BR_ALWAYS, or when any mask bit lines up with a set flag bit.
// A mask of BR_NEVER therefore never resolves taken.
module br_resolve
   import alu_pkg::*;
(
   input  logic [2:0] br_cond_i,
   input  logic [2:0] flags_i,
   output logic       taken_o
);

   logic hit_lt;
   logic hit_eq;
   logic hit_gt;

   // Per-condition matches against the architectural flags, then the OR.
   always_comb begin
      hit_lt  = br_cond_i[FLAG_LT] & flags_i[FLAG_LT];
      hit_eq  = br_cond_i[FLAG_EQ] & flags_i[FLAG_EQ];
      hit_gt  = br_cond_i[FLAG_GT] & flags_i[FLAG_GT];
      taken_o = (br_cond_i == BR_ALWAYS) | hit_lt | hit_eq | hit_gt;
   end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result register sitting directly after the ALU.
// - One-entry valid/ready output buffer with back-to-back throughput.
// - Owns the architectural flag register written by CMP/CMPR.
// - Resolves conditional branches against the flags held before the edge
//   and emits a one-cycle br_taken pulse.
// Optional build macro EX_RESULT_STATS_EN adds wrap-around counters for
// retired beats, taken branches and stall cycles.
//
// Handshake: a beat moves on a port in the cycle where its valid and ready
// are both high at the rising edge. Upstream is accepted when
// in_valid & in_ready & !flush, with in_ready = !out_valid | out_ready.
// Downstream retires the held entry when out_valid & out_ready. While
// out_valid is high and out_ready is low every out_* field holds stable.
// flush discards the held entry and the incoming beat, and never alters
// the flag register.
module ex_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W    = ALU_DATA_W,
   parameter int REG_IDX_W = ALU_REG_IDX_W,
   parameter int OPCODE_W  = ALU_OPCODE_W,
   parameter int STAT_W    = 32
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    alu_out,
   input  logic [2:0]           alu_flags,
   input  logic                 alu_set_flags,
   input  logic [OPCODE_W-1:0]  in_opcode,
   input  logic [REG_IDX_W-1:0] in_dst,
   input  logic                 in_wb_en,
   input  logic                 in_is_branch,
   input  logic [2:0]           in_br_cond,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_data,
   output logic [OPCODE_W-1:0]  out_opcode,
   output logic [REG_IDX_W-1:0] out_dst,
   output logic                 out_wb_en,
   output logic [2:0]           flags_q,
   output logic                 br_taken
`ifdef EX_RESULT_STATS_EN
   ,
   output logic [STAT_W-1:0]    stat_retired,
   output logic [STAT_W-1:0]    stat_br_taken,
   output logic [STAT_W-1:0]    stat_stall
`endif
);

   // The held entry uses the package struct, so the widths must agree.
   generate
      if (DATA_W != ALU_DATA_W || REG_IDX_W != ALU_REG_IDX_W ||
          OPCODE_W != ALU_OPCODE_W || STAT_W < 1) begin : g_bad_cfg
         $error("ex_result_stage: widths must match alu_pkg and STAT_W >= 1");
      end
   endgenerate

   ex_entry_t  entry_q;
   ex_entry_t  entry_d;
   logic       out_valid_q;
   logic       out_valid_d;
   logic [2:0] flags_d;
   logic       br_taken_d;
   logic       accept;
   logic       br_hit;

   assign in_ready = !out_valid_q | out_ready;
   assign accept   = in_valid & in_ready & !flush;

   // Branch evaluation always sees the flag register as it stands now,
   // i.e. before any CMP in this same beat updates it.
   br_resolve u_br_resolve (
      .br_cond_i (in_br_cond),
      .flags_i   (flags_q),
      .taken_o   (br_hit)
   );

   // Next-state selection: flush wins, then accept (load or replace), then drain.
   always_comb begin
      out_valid_d = out_valid_q;
      entry_d     = entry_q;
      flags_d     = flags_q;
      br_taken_d  = 1'b0;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d    = 1'b1;
         entry_d.data   = alu_out;
         entry_d.opcode = in_opcode;
         entry_d.dst    = in_dst;
         entry_d.wb_en  = in_wb_en & !in_is_branch;
         if (alu_set_flags) begin
            flags_d = alu_flags;
         end
         br_taken_d = in_is_branch & br_hit;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset clears the entry immediately, mid-transfer or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         entry_q     <= '0;
         flags_q     <= 3'b000;
         br_taken    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         entry_q     <= entry_d;
         flags_q     <= flags_d;
         br_taken    <= br_taken_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = entry_q.data;
   assign out_opcode = entry_q.opcode;
   assign out_dst    = entry_q.dst;
   assign out_wb_en  = entry_q.wb_en;

`ifdef EX_RESULT_STATS_EN
   logic [STAT_W-1:0] stat_retired_q;
   logic [STAT_W-1:0] stat_br_taken_q;
   logic [STAT_W-1:0] stat_stall_q;

   // Free-running event counters; they wrap silently at 2^STAT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_retired_q  <= '0;
         stat_br_taken_q <= '0;
         stat_stall_q    <= '0;
      end else begin
         if (out_valid_q & out_ready) begin
            stat_retired_q <= stat_retired_q + STAT_W'(1);
         end
         if (br_taken) begin
            stat_br_taken_q <= stat_br_taken_q + STAT_W'(1);
         end
         if (out_valid_q & !out_ready) begin
            stat_stall_q <= stat_stall_q + STAT_W'(1);
         end
      end
   end

   assign stat_retired  = stat_retired_q;
   assign stat_br_taken = stat_br_taken_q;
   assign stat_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Testbench for ex_result_stage: a driver issues directed and random beats
// and a cycle-level reference model pushes the expected results; a monitor
// pops and compares whenever the stage presents its output.
module tb_ex_result_stage;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int OW = 5;
  localparam int SW = 32;
  localparam int EW = DW + OW + RW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_out;
  logic [2:0]    alu_flags;
  logic          alu_set_flags;
  logic [OW-1:0] in_opcode;
  logic [RW-1:0] in_dst;
  logic          in_wb_en;
  logic          in_is_branch;
  logic [2:0]    in_br_cond;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [OW-1:0] out_opcode;
  logic [RW-1:0] out_dst;
  logic          out_wb_en;
  logic [2:0]    flags_q;
  logic          br_taken;
`ifdef EX_RESULT_STATS_EN
  logic [SW-1:0] stat_retired;
  logic [SW-1:0] stat_br_taken;
  logic [SW-1:0] stat_stall;
`endif

  ex_result_stage #(
    .DATA_W(DW), .REG_IDX_W(RW), .OPCODE_W(OW), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_set_flags(alu_set_flags),
    .in_opcode(in_opcode), .in_dst(in_dst), .in_wb_en(in_wb_en),
    .in_is_branch(in_is_branch), .in_br_cond(in_br_cond), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_opcode(out_opcode), .out_dst(out_dst), .out_wb_en(out_wb_en),
    .flags_q(flags_q), .br_taken(br_taken)
`ifdef EX_RESULT_STATS_EN
    , .stat_retired(stat_retired), .stat_br_taken(stat_br_taken), .stat_stall(stat_stall)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] data;
    logic [2:0]    flags;
    logic          set_flags;
    logic [OW-1:0] opcode;
    logic [RW-1:0] dst;
    logic          wb_en;
    logic          is_branch;
    logic [2:0]    br_cond;
    logic          flush;
    logic          out_ready;
  } stim_t;

  int checks   = 0;
  int failures = 0;

  // Expected retired entries {data, opcode, dst, wb_en}, in order.
  logic [EW-1:0] exp_q[$];
  // Expected per-cycle state {out_valid, flags[2:0], br_taken}.
  logic [4:0]    st_q[$];

  logic       m_valid;
  logic [2:0] m_flags;
  bit         mon_stop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t base_stim();
    stim_t s;
    s.in_valid  = 1'b0;
    s.data      = '0;
    s.flags     = 3'b000;
    s.set_flags = 1'b0;
    s.opcode    = OP_ADD;
    s.dst       = '0;
    s.wb_en     = 1'b0;
    s.is_branch = 1'b0;
    s.br_cond   = 3'b000;
    s.flush     = 1'b0;
    s.out_ready = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    in_valid      = s.in_valid;
    alu_out       = s.data;
    alu_flags     = s.flags;
    alu_set_flags = s.set_flags;
    in_opcode     = s.opcode;
    in_dst        = s.dst;
    in_wb_en      = s.wb_en;
    in_is_branch  = s.is_branch;
    in_br_cond    = s.br_cond;
    flush         = s.flush;
    out_ready     = s.out_ready;
  endtask

  // ---------------- driver + reference model ----------------
  task automatic drive_cycle(input stim_t s);
    logic acc;
    logic br;
    @(posedge clk);
    #1;
    apply(s);
    acc = s.in_valid && (!m_valid || s.out_ready) && !s.flush;
    br  = 1'b0;
    if (acc && s.is_branch)
      br = (s.br_cond == 3'b111) || ((s.br_cond & m_flags) != 3'b000);
    if (acc) exp_q.push_back({s.data, s.opcode, s.dst, s.wb_en && !s.is_branch});
    if (acc && s.set_flags) m_flags = s.flags;
    if (s.flush)                      m_valid = 1'b0;
    else if (acc)                     m_valid = 1'b1;
    else if (m_valid && s.out_ready)  m_valid = 1'b0;
    st_q.push_back({m_valid, m_flags, br});
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor_loop();
    logic [4:0] s;
`ifdef EX_RESULT_STATS_EN
    logic [SW-1:0] c_ret = '0;
    logic [SW-1:0] c_br  = '0;
    logic [SW-1:0] c_st  = '0;
`endif
    while (1) begin
      @(negedge clk);
      if (mon_stop) break;
      if (st_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL state_queue_underflow @%0t", $time);
        continue;
      end
      s = st_q.pop_front();
      chk("out_valid", out_valid, s[4]);
      chk("flags_q", flags_q, s[3:1]);
      chk("br_taken", br_taken, s[0]);
      chk("in_ready", in_ready, !s[4] || out_ready);
`ifdef EX_RESULT_STATS_EN
      chk("stat_retired", stat_retired, c_ret);
      chk("stat_br_taken", stat_br_taken, c_br);
      chk("stat_stall", stat_stall, c_st);
      if (s[4] && out_ready)  c_ret = c_ret + 1;
      if (s[4] && !out_ready) c_st  = c_st + 1;
      if (s[0])               c_br  = c_br + 1;
`endif
      if (s[4]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL entry_missing actual=valid required=empty @%0t", $time);
        end else begin
          chk("out_entry", {out_data, out_opcode, out_dst, out_wb_en}, exp_q[0]);
          if (flush || out_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    m_valid  = 1'b0;
    m_flags  = 3'b000;
    mon_stop = 1'b0;
    s = base_stim();
    s.out_ready = 1'b0;
    apply(s);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_wb_en", out_wb_en, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    // States seen at the two negedges before the first driven edge.
    st_q.push_back(5'b0_000_0);
    st_q.push_back(5'b0_000_0);
    fork
      monitor_loop();
    join_none

    // ADD writes FFFF to r3; flags untouched.
    s = base_stim();
    s.in_valid = 1'b1; s.data = 16'hFFFF; s.dst = 4'd3; s.wb_en = 1'b1; s.opcode = OP_ADD;
    drive_cycle(s);
    drive_cycle(base_stim());

    // CMP sets GT, branch on GT taken; then branch on LT not taken.
    s = base_stim();
    s.in_valid = 1'b1; s.opcode = OP_CMP; s.set_flags = 1'b1; s.flags = 3'b001;
    drive_cycle(s);
    s = base_stim();
    s.in_valid = 1'b1; s.opcode = OP_SUB; s.is_branch = 1'b1; s.br_cond = 3'b001; s.wb_en = 1'b1;
    drive_cycle(s);
    s.br_cond = 3'b100;
    drive_cycle(s);
    s.br_cond = BR_NEVER;
    drive_cycle(s);
    s.br_cond = BR_ALWAYS;
    drive_cycle(s);
    // CMPR that is also a branch: uses old flags (001), then flags become 100.
    s = base_stim();
    s.in_valid = 1'b1; s.opcode = OP_CMPR; s.set_flags = 1'b1; s.flags = 3'b100;
    s.is_branch = 1'b1; s.br_cond = 3'b100;
    drive_cycle(s);
    drive_cycle(base_stim());

    // Backpressure: 1234 held for three cycles while 5678 waits.
    s = base_stim();
    s.in_valid = 1'b1; s.data = 16'h1234; s.dst = 4'd7; s.wb_en = 1'b1;
    drive_cycle(s);
    s.data = 16'h5678; s.dst = 4'd8; s.out_ready = 1'b0;
    repeat (3) drive_cycle(s);
    s.out_ready = 1'b1;
    drive_cycle(s);
    drive_cycle(base_stim());
    drive_cycle(base_stim());

    // Flush with a held entry and an incoming CMP.
    s = base_stim();
    s.in_valid = 1'b1; s.data = 16'h00AA; s.wb_en = 1'b1; s.out_ready = 1'b0;
    drive_cycle(s);
    s = base_stim();
    s.in_valid = 1'b1; s.opcode = OP_CMP; s.set_flags = 1'b1; s.flags = 3'b100; s.flush = 1'b1;
    drive_cycle(s);
    drive_cycle(base_stim());

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [OW-1:0] ops[4];
      ops[0] = OP_CMP; ops[1] = OP_CMPR; ops[2] = OP_ADD; ops[3] = OP_SUB;
      s = base_stim();
      s.in_valid  = ($urandom_range(0, 9) < 7);
      s.data      = DW'($urandom);
      s.opcode    = ops[$urandom_range(0, 3)];
      s.set_flags = (s.opcode == OP_CMP) || (s.opcode == OP_CMPR);
      s.flags     = 3'($urandom_range(0, 7));
      s.dst       = RW'($urandom_range(0, 15));
      s.wb_en     = 1'($urandom_range(0, 1));
      s.is_branch = ($urandom_range(0, 3) == 0);
      s.br_cond   = 3'($urandom_range(0, 7));
      s.flush     = ($urandom_range(0, 19) == 0);
      s.out_ready = ($urandom_range(0, 9) < 7);
      drive_cycle(s);
    end
    repeat (3) drive_cycle(base_stim());

    @(negedge clk);
    #1;
    mon_stop = 1'b1;
    chk("drain_empty", exp_q.size(), 0);

    // Asynchronous reset with a held entry and flags 010.
    @(posedge clk);
    #1;
    s = base_stim();
    s.in_valid = 1'b1; s.opcode = OP_CMP; s.set_flags = 1'b1; s.flags = 3'b010;
    s.data = 16'hABCD; s.dst = 4'd5; s.wb_en = 1'b1; s.out_ready = 1'b0;
    apply(s);
    @(posedge clk);
    #1;
    s.in_valid = 1'b0;
    apply(s);
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_flags", flags_q, 3'b010);
    chk("pre_rst_out_data", out_data, 16'hABCD);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_flags", flags_q, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_wb_en", out_wb_en, 0);
    chk("arst_br_taken", br_taken, 0);
    chk("arst_in_ready", in_ready, 1);
`ifdef EX_RESULT_STATS_EN
    chk("arst_stat_retired", stat_retired, 0);
    chk("arst_stat_stall", stat_stall, 0);
`endif
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
